alu_share_arb: RTL and testbench
================================

# alu_share_arb

Two-requester arbiter that time-shares the core's single combinational `alu` between the integer pipeline (requester 0) and the address-generation / auxiliary unit (requester 1). It uses round-robin arbitration with valid/ready handshakes on both request and response sides, and a one-entry registered response slot. It sits between the decode/issue logic and the `alu` instance it owns.

## Interface
- `XLEN`, 32, operand/result width
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  2  per-requester request valid (bit i = requester i)
- `req_ready`  out  2  per-requester request accept
- `req0_a`, `req0_b`  in  XLEN each  requester 0 operands
- `req0_op`  in  4  requester 0 ALU op code
- `req1_a`, `req1_b`  in  XLEN each  requester 1 operands
- `req1_op`  in  4  requester 1 ALU op code
- `rsp_valid`  out  2  one-hot response valid, routed to the owning requester
- `rsp_ready`  in  2  per-requester response accept
- `rsp_result`  out  XLEN  registered ALU result
- `rsp_zero`  out  1  registered result==0 flag
- `rsp_illegal`  out  1  registered flag: op code not in {0010 add, 0110 sub, 0000 and, 0001 or}

## Operation
- Op codes: 0010 a+b, 0110 a−b, 0000 a&b, 0001 a|b; all others give result 0, zero 1, illegal 1.
- Arithmetic is modulo 2^XLEN. Carry and borrow are discarded.
- Arbitration: `last` register (1 bit) records the most recently accepted requester.
  - Priority goes to requester `~last`.
  - If only one requester is valid, it wins regardless of `last`.
- Response slot states:
  - EMPTY: `rsp_valid`=00.
  - FULL(id): `rsp_valid` is one-hot at `id`.
- `slot_free` = EMPTY, or (FULL(id) and `rsp_ready[id]`).
- `req_ready[i]` = grant[i] & `slot_free`. At most one bit is set. Ready may depend combinationally on `req_valid` and `rsp_ready`.
- Transfer on `req_valid[i]` & `req_ready[i]`:
  - Muxed operands/op drive `alu`.
  - `result`, `zero` and `illegal` are captured into the slot; slot → FULL(i).
  - `last` ← i.
- Drain without new transfer: FULL(id) & `rsp_ready[id]` → EMPTY.
- `rsp_ready` bits for non-owning requesters are ignored.
- Response data is held stable while FULL and not accepted.

## Timing
- Reset values: `rsp_valid`=00, `rsp_result`=0, `rsp_zero`=0, `rsp_illegal`=0, `last`=1 (requester 0 favoured first), slot EMPTY.
- Latency: request accepted at edge N → `rsp_valid` high after edge N, i.e. one cycle.
- Throughput: one op per cycle sustained when the owning consumer holds `rsp_ready` high.
- Simultaneous drain + accept: allowed in the same cycle. The slot goes FULL(new id) with no bubble.
- Both requesters valid every cycle: grants alternate 0,1,0,1… starting with 0 after reset.
- Requester drops `req_valid` before being granted: legal. No state changes.
- Reset asserted mid-operation:
  - The slot is cleared immediately (asynchronous). Any pending response is lost.
  - `req_ready` goes 0 while `rst_n` is low.
- No combinational path from `rsp_*` outputs to any input except through `slot_free` → `req_ready`.

## Structure
- Shared package `alu_pkg`:
  - op code localparams `ALU_ADD`=4'b0010, `ALU_SUB`=4'b0110, `ALU_AND`=4'b0000, `ALU_OR`=4'b0001
  - `alu_op_legal()` function
  - requester id constants `REQ_PIPE`=0, `REQ_AUX`=1
- Sub-module `rr_arb2`: 2-way round-robin grant from `req_valid` and `last`. It is purely combinational; `last` lives in the parent.
- The existing `alu` module is instantiated unchanged. `rsp_illegal` is computed in parallel from the package function.

## Test plan
- Reset then single request: r0 a=5, b=3, op=0010, `rsp_ready`=11 → one cycle later `rsp_valid`=01, result=8, zero=0, illegal=0.
- Contention: both valid every cycle, r0 op=0110 a=7 b=7, r1 op=0001 a=0xF0 b=0x0F → responses alternate; r0 result=0 with zero=1, r1 result=0xFF; order 0,1,0,1.
- Backpressure:
  - r1 issues 0xFFFFFFFF+1 (op 0010) with `rsp_ready[1]`=0 for 3 cycles → result=0, zero=1 held stable; `req_ready`=00 throughout while r0 is valid.
  - Then `rsp_ready[1]`=1 → r0 is accepted in the same cycle (no bubble).
- Illegal op: r0 op=1111 → result=0, zero=1, illegal=1; next legal op clears illegal.
- Non-owner ready: slot FULL(0), `rsp_ready`=10 → slot stays FULL(0) and no new grant.
- Mid-operation reset: assert `rst_n`=0 while slot FULL(1) → `rsp_valid`=00 immediately; after release, first contended grant goes to r0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the shared-ALU arbiter.
//   - ALU op code constants and the legality check used for rsp_illegal
//   - requester ids (pipeline = 0, auxiliary/AGU = 1)
//   - response slot state type, also exported as a debug output
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  localparam logic REQ_PIPE = 1'b0;
  localparam logic REQ_AUX  = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic alu_op_legal(input logic [3:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) || (op == ALU_OR);
  endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: request/response bundle between issue logic and the
// shared-ALU arbiter.
//   master : issue side (drives requests, consumes responses)
//   slave  : arbiter side
// Handshake: a transfer happens on any rising clock edge where valid and
// ready are both 1 for the same requester bit; valid must not wait on
// ready, and ready may depend combinationally on valid.
interface alu_share_arb_if #(
  parameter int XLEN = 32
);
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [XLEN-1:0] req0_a;
  logic [XLEN-1:0] req0_b;
  logic [3:0]      req0_op;
  logic [XLEN-1:0] req1_a;
  logic [XLEN-1:0] req1_b;
  logic [3:0]      req1_op;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [XLEN-1:0] rsp_result;
  logic            rsp_zero;
  logic            rsp_illegal;

  modport master (
    output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal
  );

  modport slave (
    input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal
  );
endinterface

// File: rtl/alu.sv
// alu: combinational integer ALU.
//   a, b   : operands
//   op     : ALU_ADD / ALU_SUB / ALU_AND / ALU_OR; other codes give 0
//   result : modulo-2^XLEN result (carry/borrow dropped)
//   zero   : result == 0
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin grant.
//   req_valid : per-requester request
//   last      : requester accepted most recently (held by the parent)
//   grant     : one-hot winner, 00 when nobody requests
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // contention: whoever was not served last goes first
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: time-shares one ALU between the integer pipeline
// (requester 0) and the auxiliary unit (requester 1), with a one-entry
// registered response slot.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response bundle (slave side)
//   dbg_state  : response slot state
//   dbg_last   : requester accepted most recently
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_share_arb_if.slave        bus,
  output slot_state_e           dbg_state,
  output logic                  dbg_last
);

  slot_state_e     state_q;
  logic [1:0]      rsp_valid_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            illegal_q;
  logic            last_q;

  logic [1:0]      grant;
  logic            slot_free;
  logic [1:0]      ready;
  logic            accept;
  logic            drain;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic            op_illegal;

  rr_arb2 u_arb (
    .req_valid (bus.req_valid),
    .last      (last_q),
    .grant     (grant)
  );

  // Only the owning requester's rsp_ready matters: rsp_valid_q is one-hot.
  assign drain     = (state_q == SLOT_FULL) && (|(rsp_valid_q & bus.rsp_ready));
  assign slot_free = (state_q == SLOT_EMPTY) || drain;
  // rst_n gating keeps ready low for the whole time reset is held.
  assign ready     = grant & {2{slot_free & rst_n}};
  assign accept    = |(bus.req_valid & ready);

  // Operand mux follows the grant, not ready, so it has no path from rsp_ready.
  assign alu_a  = grant[REQ_AUX] ? bus.req1_a  : bus.req0_a;
  assign alu_b  = grant[REQ_AUX] ? bus.req1_b  : bus.req0_b;
  assign alu_op = grant[REQ_AUX] ? bus.req1_op : bus.req0_op;

  alu #(.XLEN(XLEN)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  assign op_illegal = ~alu_op_legal(alu_op);

  // Slot FSM; an accept in the same cycle as a drain refills with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SLOT_EMPTY;
      rsp_valid_q <= 2'b00;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      last_q      <= REQ_AUX;
    end else if (accept) begin
      state_q     <= SLOT_FULL;
      rsp_valid_q <= ready;
      result_q    <= alu_result;
      zero_q      <= alu_zero;
      illegal_q   <= op_illegal;
      last_q      <= ready[REQ_AUX];
    end else if (drain) begin
      state_q     <= SLOT_EMPTY;
      rsp_valid_q <= 2'b00;
    end
  end

  assign bus.req_ready   = ready;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = result_q;
  assign bus.rsp_zero    = zero_q;
  assign bus.rsp_illegal = illegal_q;
  assign dbg_state       = state_q;
  assign dbg_last        = last_q;

endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;
  import alu_pkg::*;

  localparam int XLEN = 32;
  localparam int W    = XLEN + 2;   // {illegal, zero, result}

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_share_arb_if #(.XLEN(XLEN)) bus ();
  slot_state_e dbg_state;
  logic        dbg_last;

  alu_share_arb #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_last  (dbg_last)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_op(input logic [3:0] op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    logic            ill;
    ill = 1'b0;
    case (op)
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      default: begin r = '0; ill = 1'b1; end
    endcase
    return {ill, (r == '0), r};
  endfunction

  logic [W-1:0] exp_q[$];      // response held in the slot
  logic         grant_log[$];  // order of accepted requesters
  logic         m_full = 1'b0;
  logic         m_id   = 1'b0;
  logic         m_last = 1'b1;

  // Scoreboard: outputs are checked mid-cycle against the model, then the
  // model advances as if the coming rising edge had happened.
  always @(negedge clk) begin
    logic [1:0] exp_ready;
    logic       winner;
    logic       free;
    if (!rst_n) begin
      check("rst_rsp_valid", bus.rsp_valid, 2'b00);
      check("rst_req_ready", bus.req_ready, 2'b00);
      check("rst_result", bus.rsp_result, '0);
      check("rst_zero", bus.rsp_zero, 1'b0);
      check("rst_illegal", bus.rsp_illegal, 1'b0);
      exp_q.delete();
      m_full = 1'b0;
      m_last = 1'b1;
    end else begin
      check("sb_rsp_valid", bus.rsp_valid, m_full ? (m_id ? 2'b10 : 2'b01) : 2'b00);
      check("sb_state", dbg_state, m_full ? SLOT_FULL : SLOT_EMPTY);
      if (m_full && exp_q.size() > 0) begin
        check("sb_result", bus.rsp_result, exp_q[0][XLEN-1:0]);
        check("sb_zero", bus.rsp_zero, exp_q[0][XLEN]);
        check("sb_illegal", bus.rsp_illegal, exp_q[0][XLEN+1]);
      end
      free = !m_full || bus.rsp_ready[m_id];
      if (bus.req_valid == 2'b11) winner = ~m_last;
      else                        winner = bus.req_valid[1];
      exp_ready = (bus.req_valid != 2'b00 && free) ? (winner ? 2'b10 : 2'b01) : 2'b00;
      check("sb_req_ready", bus.req_ready, exp_ready);
      if (exp_ready != 2'b00) begin
        if (m_full) void'(exp_q.pop_front());
        if (winner) exp_q.push_back(model_op(bus.req1_op, bus.req1_a, bus.req1_b));
        else        exp_q.push_back(model_op(bus.req0_op, bus.req0_a, bus.req0_b));
        m_full = 1'b1;
        m_id   = winner;
        m_last = winner;
        grant_log.push_back(winner);
      end else if (m_full && bus.rsp_ready[m_id]) begin
        void'(exp_q.pop_front());
        m_full = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_r0(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    bus.req0_op = op;
    bus.req0_a  = a;
    bus.req0_b  = b;
  endtask

  task automatic drive_r1(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    bus.req1_op = op;
    bus.req1_a  = a;
    bus.req1_b  = b;
  endtask

  // ---------------- directed stimulus ----------------
  logic [1:0]      con_valid [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [XLEN-1:0] con_result[4] = '{32'h0, 32'hFF, 32'h0, 32'hFF};
  logic            con_zero  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic            con_id    [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    drive_r0(4'b0000, '0, '0);
    drive_r1(4'b0000, '0, '0);

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_last", dbg_last, 1'b1);
    check("reset_state", dbg_state, SLOT_EMPTY);
    tick();
    rst_n = 1'b1;

    // single request, one-cycle latency
    drive_r0(4'b0010, 32'd5, 32'd3);
    bus.req_valid = 2'b01;
    @(negedge clk);
    check("t1_req_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("t1_rsp_valid", bus.rsp_valid, 2'b01);
    check("t1_result", bus.rsp_result, 32'd8);
    check("t1_zero", bus.rsp_zero, 1'b0);
    check("t1_illegal", bus.rsp_illegal, 1'b0);
    tick();

    // single r1 request leaves last = 1
    drive_r1(4'b0110, 32'h10, 32'h3);
    bus.req_valid = 2'b10;
    tick();
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("r1_rsp_valid", bus.rsp_valid, 2'b10);
    check("r1_result", bus.rsp_result, 32'hD);
    tick();

    // contention: grants alternate 0,1,0,1
    grant_log.delete();
    drive_r0(4'b0110, 32'd7, 32'd7);
    drive_r1(4'b0001, 32'hF0, 32'h0F);
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) bus.req_valid = 2'b00;
      @(negedge clk);
      check("con_rsp_valid", bus.rsp_valid, con_valid[i]);
      check("con_result", bus.rsp_result, con_result[i]);
      check("con_zero", bus.rsp_zero, con_zero[i]);
    end
    tick();
    check("con_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("con_grant_order", grant_log[i], con_id[i]);

    // backpressure on r1, r0 waiting
    drive_r1(4'b0010, 32'hFFFF_FFFF, 32'h1);
    bus.req_valid = 2'b10;
    tick();
    drive_r0(4'b0000, 32'hF0F0, 32'hFF00);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", bus.rsp_valid, 2'b10);
      check("bp_result", bus.rsp_result, 32'h0);
      check("bp_zero", bus.rsp_zero, 1'b1);
      check("bp_req_ready", bus.req_ready, 2'b00);
      tick();
    end
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    check("bp_release_ready", bus.req_ready, 2'b01);
    tick();
    @(negedge clk);
    check("bp_r0_rsp_valid", bus.rsp_valid, 2'b01);
    check("bp_r0_result", bus.rsp_result, 32'hF000);

    // illegal op, then a legal op clears the flag
    drive_r0(4'b1111, 32'h1234, 32'h5678);
    tick();
    drive_r0(4'b0001, 32'h1, 32'h2);
    @(negedge clk);
    check("ill_result", bus.rsp_result, 32'h0);
    check("ill_zero", bus.rsp_zero, 1'b1);
    check("ill_flag", bus.rsp_illegal, 1'b1);
    tick();
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b10;
    @(negedge clk);
    check("legal_flag", bus.rsp_illegal, 1'b0);
    check("legal_result", bus.rsp_result, 32'h3);

    // non-owner ready is ignored: slot stays FULL(0), no grant
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      check("nonown_rsp_valid", bus.rsp_valid, 2'b01);
      check("nonown_result", bus.rsp_result, 32'h3);
      check("nonown_req_ready", bus.req_ready, 2'b00);
    end
    tick();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    tick();

    // reset while slot FULL(1)
    drive_r1(4'b0110, 32'd9, 32'd9);
    bus.req_valid = 2'b10;
    bus.rsp_ready = 2'b00;
    tick();
    bus.req_valid = 2'b00;
    #1;
    check("mr_pre_rsp_valid", bus.rsp_valid, 2'b10);
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    #1;
    check("mr_rsp_valid", bus.rsp_valid, 2'b00);
    check("mr_req_ready", bus.req_ready, 2'b00);
    check("mr_state", dbg_state, SLOT_EMPTY);
    tick();
    rst_n = 1'b1;
    drive_r0(4'b0010, 32'd1, 32'd1);
    drive_r1(4'b0010, 32'd4, 32'd4);
    @(negedge clk);
    check("mr_first_grant", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("mr_rsp_valid_after", bus.rsp_valid, 2'b01);
    check("mr_result_after", bus.rsp_result, 32'd2);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
